// File: rtl/prg_fetch.sv
// ---------------------------------------------------------------------------
// prg_fetch
//
// Program counter and instruction fetch stage of the 4-bit CPU. It reads one
// 8-bit machine code per instruction from program ROM and holds it in the
// instruction register (MC_CODE). For one cycle it raises EXEC so the
// downstream decoder can act on that code. On the edge that ends EXEC it
// updates the program counter and the carry flag from the decoder's requests.
//
// Optional feature macro: PRG_FETCH_WDT_EN
//   When defined, a ROM acknowledge watchdog is added, along with the WDT_ERR
//   port. If ROM_ACK stays low for P_ACK_TO fetch cycles, the stage injects
//   JMP 0 (8'hD0) and sets a sticky error flag.
//
// Parameters
//   P_RST_VEC   program counter value after reset
//   P_ACK_TO    watchdog limit in fetch wait cycles (watchdog build only)
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-high reset
//   RUN         fetch enable (level); sampled in IDLE and EXEC only
//   ROM_D       ROM read data, valid while ROM_ACK = 1
//   ROM_ACK     ROM data valid
//   PRG_CNT_LD  decoder jump request, honoured in EXEC only
//   CARRY_LD    decoder carry load request, honoured in EXEC only
//   ALU_CO      ALU carry-out
//   ROM_A       ROM address (always equals PC)
//   ROM_RD      ROM read request (high in FETCH)
//   MC_CODE     instruction register
//   EXEC        execute strobe, one cycle per instruction
//   CARRY       carry flag register
//   PC          program counter
//   WDT_ERR     sticky ROM timeout flag (watchdog build only)
// ---------------------------------------------------------------------------
module prg_fetch #(
  parameter logic [3:0] P_RST_VEC = 4'h0,
  parameter logic [3:0] P_ACK_TO  = 4'hF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic [7:0] ROM_D,
  input  logic       ROM_ACK,
  input  logic       PRG_CNT_LD,
  input  logic       CARRY_LD,
  input  logic       ALU_CO,
  output logic [3:0] ROM_A,
  output logic       ROM_RD,
  output logic [7:0] MC_CODE,
  output logic       EXEC,
  output logic       CARRY,
  output logic [3:0] PC
`ifdef PRG_FETCH_WDT_EN
  ,
  output logic       WDT_ERR
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // High when the current fetch cycle is abandoned by the watchdog.
  logic timeout;

  assign ROM_A = PC;

`ifdef PRG_FETCH_WDT_EN
  logic [3:0] wait_cnt;

  // The counter is compared against P_ACK_TO-1 because the timeout fires on
  // the same edge that would have incremented it to P_ACK_TO. That gives
  // exactly P_ACK_TO unacknowledged fetch cycles before JMP 0 is injected.
  assign timeout = (state == S_FETCH) && !ROM_ACK &&
                   (wait_cnt == (P_ACK_TO - 4'd1));

  // Wait counter and sticky error flag. The counter restarts whenever FETCH is
  // entered, whether the previous state was IDLE or EXEC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= 4'd0;
      WDT_ERR  <= 1'b0;
    end else begin
      if ((state_next == S_FETCH) && (state != S_FETCH)) begin
        wait_cnt <= 4'd0;
      end else if ((state == S_FETCH) && !ROM_ACK) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (timeout) begin
        WDT_ERR <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog, FETCH waits for ROM_ACK indefinitely. The timeout
  // parameter is still part of the interface, so it is folded into a
  // deliberately unused net.
  logic unused_ack_to;
  assign unused_ack_to = ^P_ACK_TO;
  assign timeout       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the strobes that depend only on the state. RUN is looked
  // at only in IDLE and EXEC, so a fetch that has started always completes and
  // executes.
  always_comb begin
    state_next = state;
    ROM_RD     = 1'b0;
    EXEC       = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        ROM_RD = 1'b1;
        if (ROM_ACK || timeout) begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        EXEC       = 1'b1;
        state_next = RUN ? S_FETCH : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Instruction register, program counter and carry flag.
  // MC_CODE is loaded only on the FETCH -> EXEC edge. PC and CARRY change only
  // on the edge that ends EXEC. Because reset is asynchronous, an instruction
  // caught in EXEC is dropped without applying its update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC      <= P_RST_VEC;
      MC_CODE <= 8'h00;
      CARRY   <= 1'b0;
    end else begin
      if (state == S_FETCH) begin
        if (ROM_ACK) begin
          MC_CODE <= ROM_D;
        end else if (timeout) begin
          MC_CODE <= 8'hD0;
        end
      end
      if (state == S_EXEC) begin
        if (PRG_CNT_LD) begin
          PC <= MC_CODE[3:0];
        end else begin
          PC <= PC + 4'd1;
        end
        if (CARRY_LD) begin
          CARRY <= ALU_CO;
        end
      end
    end
  end

endmodule

// File: doc/prg_fetch.md
# prg_fetch

Program counter and instruction fetch stage for the 4-bit CPU. It sits directly upstream of the instruction decoder. It fetches an 8-bit machine code from program ROM at the current program counter, holds it in an instruction register and presents it as `MC_CODE`. During the one-cycle execute phase it takes back the decoder's `PRG_CNT_LD` and `CARRY_LD` pulses to update the program counter and the carry flag.

## Interface
- `P_RST_VEC`, default `4'h0`: program counter value after reset.
- `P_ACK_TO`, default `4'hF`: maximum wait cycles for `ROM_ACK`. Used only with `PRG_FETCH_WDT_EN`.
- `CLK`, input, 1: clock; all state changes on the rising edge.
- `RST`, input, 1: reset; asynchronous, active-high.
- `RUN`, input, 1: fetch enable; level.
- `ROM_D`, input, 8: ROM read data; valid when `ROM_ACK`=1.
- `ROM_ACK`, input, 1: ROM data valid. Tie to 1 for a zero-wait ROM.
- `PRG_CNT_LD`, input, 1: jump request from the decoder.
- `CARRY_LD`, input, 1: carry load request from the decoder.
- `ALU_CO`, input, 1: ALU carry-out.
- `ROM_A`, output, 4: ROM address; equals PC.
- `ROM_RD`, output, 1: ROM read request.
- `MC_CODE`, output, 8: instruction register.
- `EXEC`, output, 1: execute strobe. Downstream register loads are qualified by it.
- `CARRY`, output, 1: carry flag register; feeds the decoder's `CARRY`.
- `PC`, output, 4: program counter.
- `WDT_ERR`, output, 1: ROM timeout flag; present only with `PRG_FETCH_WDT_EN`.

## Operation
- States:
  - IDLE: `ROM_RD`=0, `EXEC`=0.
  - FETCH: `ROM_RD`=1, `ROM_A`=PC.
  - EXEC: `EXEC`=1, `MC_CODE` stable.
- Transitions:
  - IDLE -> FETCH when `RUN`=1.
  - FETCH -> EXEC on a cycle with `ROM_ACK`=1; `MC_CODE` <= `ROM_D` on that edge.
  - FETCH stays in FETCH while `ROM_ACK`=0; PC and `MC_CODE` hold.
  - EXEC -> FETCH if `RUN`=1, else EXEC -> IDLE.
- PC update, on the EXEC-state edge only:
  - `PRG_CNT_LD`=1: PC <= `MC_CODE[3:0]`.
  - Otherwise PC <= PC+1, modulo 16 (4'hF -> 4'h0).
- Carry, on the EXEC-state edge only: `CARRY` <= `ALU_CO` if `CARRY_LD`=1, else `CARRY` holds.
- `PRG_CNT_LD` and `CARRY_LD` are ignored outside EXEC. They are sampled together and act independently.
- `RUN` deasserting:
  - During FETCH: the fetch completes and the instruction executes. `RUN` is checked only in EXEC and IDLE.
  - During EXEC: the current instruction completes, then the block enters IDLE with PC already updated.
- `ROM_ACK` outside FETCH is ignored.
- `MC_CODE` changes only on the FETCH -> EXEC edge.

## Timing
- Reset values:
  - PC = `P_RST_VEC`
  - `ROM_A` = `P_RST_VEC`
  - `MC_CODE` = 8'h00
  - `ROM_RD` = 0
  - `EXEC` = 0
  - `CARRY` = 0
  - `WDT_ERR` = 0
  - state = IDLE
- Reset asserted mid-instruction aborts immediately. A pending EXEC never produces its PC or carry update.
- First `ROM_RD` appears in the first cycle after the first edge with `RST`=0 and `RUN`=1.
- Zero-wait ROM: 2 cycles per instruction (FETCH, EXEC). Each ROM wait cycle adds 1.
- `EXEC` is high for exactly one cycle per instruction.
- New `MC_CODE` is visible in the EXEC cycle. Decoder outputs are combinational from it and valid in the same cycle.
- PC and `CARRY` update on the edge that ends EXEC. A JNC in the next instruction sees the updated `CARRY`.

## Configuration
- `PRG_FETCH_WDT_EN` defined:
  - A 4-bit wait counter clears on FETCH entry and increments each FETCH cycle with `ROM_ACK`=0.
  - When it reaches `P_ACK_TO`, the block loads `MC_CODE` <= 8'hD0 (JMP 0) and goes to EXEC as if acknowledged.
  - `WDT_ERR` sets and stays sticky until `RST`.
- `PRG_FETCH_WDT_EN` undefined:
  - No counter and no `WDT_ERR` port.
  - FETCH waits for `ROM_ACK` indefinitely.

## Test plan
- Reset, `RUN`=1, `ROM_ACK`=1, ROM holds 8'h05 at every address -> `ROM_A` steps 0,1,2 with one EXEC pulse every 2 cycles; `MC_CODE`=8'h05.
- EXEC with `MC_CODE`=8'hD9 and `PRG_CNT_LD`=1 -> next `ROM_A`=4'h9. With PC=4'hF and no jump -> next `ROM_A`=4'h0.
- `ROM_ACK` low for 3 cycles -> `ROM_RD` held 4 cycles, PC and `MC_CODE` unchanged until the ack edge, then one EXEC pulse.
- EXEC with `CARRY_LD`=1, `ALU_CO`=1 -> `CARRY`=1. `CARRY_LD`=1 outside EXEC -> `CARRY` unchanged.
- `RUN` dropped during FETCH -> instruction executes, state goes to IDLE, `ROM_RD`=0, PC = old+1.
- `RST` pulsed during EXEC -> PC=`P_RST_VEC`, `CARRY`=0, no update from the aborted instruction.
- With `PRG_FETCH_WDT_EN`, `ROM_ACK` tied 0 -> after 15 FETCH cycles `MC_CODE`=8'hD0, `WDT_ERR`=1, next `ROM_A`=4'h0.
